// File: rtl/pe_input_pad_pkg.sv
// rtl/pe_input_pad_pkg.sv - shared PE control types: pad defaults, controller address bundle, pad state
package PECtlCfg;

    localparam int DW_DEF    = 16;
    localparam int DEPTH_DEF = 16;
    localparam int AW_DEF    = $clog2(DEPTH_DEF);

    typedef enum logic {
        PAD_IDLE   = 1'b0,
        PAD_ACTIVE = 1'b1
    } pad_state_e;

    // Read/pop request bundle driven by the datapath controller
    typedef struct packed {
        logic              rd_en;
        logic [AW_DEF-1:0] rd_off;
        logic              pop;
        logic [AW_DEF:0]   pop_num;
    } IPadAddr;

endpackage

// File: rtl/pe_pad_ram.sv
// rtl/pe_pad_ram.sv - DEPTH x DW register file, one write port, one registered read port
module pe_pad_ram #(
    parameter int DW    = 16,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_dat,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_dat
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // Read data holds its last value between reads
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_dat <= '0;
        end else if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/pe_input_pad.sv
// rtl/pe_input_pad.sv - PE input scratchpad: circular activation window read by offset from head
module pe_input_pad
    import PECtlCfg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_clear,
    input  logic          i_In_rdy,
    output logic          o_In_ack,
    input  logic [DW-1:0] i_In_dat,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_off,
    output logic [DW-1:0] o_rd_dat,
    output logic          o_rd_vld,
    input  logic          i_pop,
    input  logic [AW:0]   i_pop_num,
    output logic [AW:0]   o_count,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_err
);

    pad_state_e    state, state_nxt;
    logic [AW-1:0] head, tail, head_nxt, tail_nxt;
    logic [AW:0]   count, count_nxt, pop_amt;
    logic [AW+1:0] avail, sum;
    logic          wr, under, rd_bad, pop_bad;

    assign o_In_ack = (state == PAD_ACTIVE) && !o_full;
    assign wr       = i_In_rdy && o_In_ack && !i_clear;
    assign o_count  = count;

    always_comb begin
        state_nxt = state;
        if (i_clear) begin
            state_nxt = PAD_IDLE;
        end else if (i_start && state == PAD_IDLE) begin
            state_nxt = PAD_ACTIVE;
        end
    end

    // Occupancy update in AW+2 bits; an over-pop collapses the window onto the tail
    always_comb begin
        pop_amt   = i_pop ? i_pop_num : '0;
        avail     = {1'b0, count} + {{(AW+1){1'b0}}, wr};
        sum       = avail - {1'b0, pop_amt};
        under     = {1'b0, pop_amt} > avail;
        tail_nxt  = tail + {{(AW-1){1'b0}}, wr};
        head_nxt  = under ? tail_nxt : head + pop_amt[AW-1:0];
        count_nxt = under ? '0 : sum[AW:0];
        pop_bad   = pop_amt > count;
        rd_bad    = i_rd_en && ((state == PAD_IDLE) || ({1'b0, i_rd_off} >= count));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= PAD_IDLE;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            o_full   <= 1'b0;
            o_empty  <= 1'b1;
            o_rd_vld <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            state <= state_nxt;
            o_err <= o_err | rd_bad | pop_bad;
            if (i_clear) begin
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                o_full   <= 1'b0;
                o_empty  <= 1'b1;
                o_rd_vld <= 1'b0;
            end else begin
                head     <= head_nxt;
                tail     <= tail_nxt;
                count    <= count_nxt;
                o_full   <= (count_nxt == (AW+1)'(DEPTH));
                o_empty  <= (count_nxt == '0);
                o_rd_vld <= i_rd_en;
            end
        end
    end

    pe_pad_ram #(
        .DW   (DW),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_ram (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .wr_en  (wr),
        .wr_addr(tail),
        .wr_dat (i_In_dat),
        .rd_en  (i_rd_en),
        .rd_addr(head + i_rd_off),
        .rd_dat (o_rd_dat)
    );

endmodule

// File: tb/tb_pe_input_pad.sv
// tb/tb_pe_input_pad.sv - scoreboard bench for pe_input_pad
module tb_pe_input_pad;

    logic        clk = 1'b0;
    logic        rst_n, start, clear, rdy, ack, rd_en, pop, rd_vld, full, empty, err;
    logic [15:0] dat, rd_dat;
    logic [3:0]  rd_off;
    logic [4:0]  pop_num, count;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mdl[$];
    bit          m_active = 0;

    always #5 clk = ~clk;

    pe_input_pad dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (start),
        .i_clear  (clear),
        .i_In_rdy (rdy),
        .o_In_ack (ack),
        .i_In_dat (dat),
        .i_rd_en  (rd_en),
        .i_rd_off (rd_off),
        .o_rd_dat (rd_dat),
        .o_rd_vld (rd_vld),
        .i_pop    (pop),
        .i_pop_num(pop_num),
        .o_count  (count),
        .o_full   (full),
        .o_empty  (empty),
        .o_err    (err)
    );

    // Scoreboard consumer: every valid read must match the oldest pending expectation
    always @(negedge clk) begin
        if (rst_n && rd_vld) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected: got vld with data %0d, want no read", rd_dat);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (rd_dat !== e) begin
                    bad++;
                    $display("FAIL rd_dat: got %0d want %0d", rd_dat, e);
                end
            end
        end
    end

    // Advance one clock, updating the reference window with the driven requests
    task automatic step();
        bit wr;
        if (rd_en && !clear) exp_q.push_back(mdl[rd_off]);
        wr = m_active && (mdl.size() < 16) && rdy && !clear;
        if (clear) begin
            mdl.delete();
            m_active = 0;
        end else begin
            if (pop && (int'(pop_num) > mdl.size() + int'(wr))) begin
                mdl.delete();
            end else begin
                if (wr) mdl.push_back(dat);
                if (pop) for (int k = 0; k < int'(pop_num); k++) void'(mdl.pop_front());
            end
            if (start) m_active = 1;
        end
        @(posedge clk);
        #1;
        start = 0; clear = 0; pop = 0; rd_en = 0;
    endtask

    task automatic test_reset();
        total += 7;
        if (ack !== 1'b0)    begin bad++; $display("FAIL rst_ack: got %b want 0", ack); end
        if (rd_vld !== 1'b0) begin bad++; $display("FAIL rst_vld: got %b want 0", rd_vld); end
        if (rd_dat !== 16'd0) begin bad++; $display("FAIL rst_dat: got %0d want 0", rd_dat); end
        if (err !== 1'b0)    begin bad++; $display("FAIL rst_err: got %b want 0", err); end
        if (empty !== 1'b1)  begin bad++; $display("FAIL rst_empty: got %b want 1", empty); end
        if (full !== 1'b0)   begin bad++; $display("FAIL rst_full: got %b want 0", full); end
        if (count !== 5'd0)  begin bad++; $display("FAIL rst_count: got %0d want 0", count); end
    endtask

    task automatic test_fill();
        start = 1;
        step();
        rdy = 1;
        for (int i = 0; i < 16; i++) begin
            dat = 16'(i);
            total++;
            if (ack !== 1'b1) begin bad++; $display("FAIL fill_ack beat %0d: got %b want 1", i, ack); end
            step();
        end
        total += 3;
        if (ack !== 1'b0)    begin bad++; $display("FAIL full_ack: got %b want 0", ack); end
        if (full !== 1'b1)   begin bad++; $display("FAIL full_flag: got %b want 1", full); end
        if (count !== 5'd16) begin bad++; $display("FAIL full_count: got %0d want 16", count); end
        dat = 16'hdead;
        step();
        total++;
        if (count !== 5'd16) begin bad++; $display("FAIL full_nowrite: got %0d want 16", count); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] offs [3] = '{4'd0, 4'd3, 4'd15};
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            rd_en = 1; rd_off = offs[i];
            step();
        end
        step();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_pending: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_pop_read();
        pop = 1; pop_num = 5'd3; rd_en = 1; rd_off = 4'd0;
        step();
        total += 2;
        if (count !== 5'd13) begin bad++; $display("FAIL pop_count: got %0d want 13", count); end
        if (ack !== 1'b1)    begin bad++; $display("FAIL pop_ack: got %b want 1", ack); end
        rd_en = 1; rd_off = 4'd0;
        step();
        step();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL pop_pending: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_wrap();
        pop = 1; pop_num = 5'd5;
        step();
        rdy = 1;
        for (int i = 0; i < 20; i++) begin
            dat = 16'(100 + i); pop = 1; pop_num = 5'd1; rd_en = 1; rd_off = 4'd7;
            step();
        end
        rdy = 0;
        step();
        total += 3;
        if (count !== 5'd8)    begin bad++; $display("FAIL wrap_count: got %0d want 8", count); end
        if (err !== 1'b0)      begin bad++; $display("FAIL wrap_err: got %b want 0", err); end
        if (exp_q.size() != 0) begin bad++; $display("FAIL wrap_pending: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_pop_saturate();
        pop = 1; pop_num = 5'd6;
        step();
        total++;
        if (count !== 5'd2) begin bad++; $display("FAIL sat_pre: got %0d want 2", count); end
        pop = 1; pop_num = 5'd5;
        step();
        total += 3;
        if (count !== 5'd0) begin bad++; $display("FAIL sat_count: got %0d want 0", count); end
        if (empty !== 1'b1) begin bad++; $display("FAIL sat_empty: got %b want 1", empty); end
        if (err !== 1'b1)   begin bad++; $display("FAIL sat_err: got %b want 1", err); end
        clear = 1;
        step();
        total += 2;
        if (err !== 1'b1) begin bad++; $display("FAIL clr_err_sticky: got %b want 1", err); end
        if (ack !== 1'b0) begin bad++; $display("FAIL clr_ack: got %b want 0", ack); end
    endtask

    task automatic test_async_reset();
        start = 1;
        step();
        rdy = 1;
        for (int i = 0; i < 9; i++) begin
            dat = 16'(200 + i);
            step();
        end
        rdy = 0; rd_en = 1; rd_off = 4'd2;
        step();
        total += 2;
        if (count !== 5'd9)  begin bad++; $display("FAIL ar_pre_count: got %0d want 9", count); end
        if (rd_vld !== 1'b1) begin bad++; $display("FAIL ar_pre_vld: got %b want 1", rd_vld); end
        exp_q.delete();
        rst_n = 0;
        #1;
        total += 4;
        if (ack !== 1'b0)    begin bad++; $display("FAIL ar_ack: got %b want 0", ack); end
        if (rd_vld !== 1'b0) begin bad++; $display("FAIL ar_vld: got %b want 0", rd_vld); end
        if (count !== 5'd0)  begin bad++; $display("FAIL ar_count: got %0d want 0", count); end
        if (err !== 1'b0)    begin bad++; $display("FAIL ar_err: got %b want 0", err); end
        mdl.delete();
        m_active = 0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        rdy = 1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (ack !== 1'b0) begin bad++; $display("FAIL ar_idle_ack: got %b want 0", ack); end
            step();
        end
        rdy = 0; start = 1;
        step();
        total++;
        if (ack !== 1'b1) begin bad++; $display("FAIL ar_start_ack: got %b want 1", ack); end
    endtask

    initial begin
        rst_n = 0; start = 0; clear = 0; rdy = 0; dat = '0;
        rd_en = 0; rd_off = '0; pop = 0; pop_num = '0;
        #12;
        test_reset();
        rst_n = 1;
        @(posedge clk);
        #1;
        test_fill();
        test_back_to_back();
        test_pop_read();
        test_wrap();
        test_pop_saturate();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pe_input_pad.md
Name: pe_input_pad

Overview:
- Input scratchpad (IPad) of the PE. Sits directly downstream of the input rdy/ack port and upstream of the PE multiply stage.
- Buffers input activations in a circular window.
- The datapath controller reads the window by offset from the head and slides it forward by popping consumed entries.
- Lets the controller reuse a row across R filter taps while new pixels stream in.

Parameters:
- DW, 16, activation data width.
- DEPTH, 16, pad entries; must be a power of two, at least 4.
- AW, $clog2(DEPTH), address/offset width.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_start  input  1  one-cycle pulse; IDLE -> ACTIVE
- i_clear  input  1  synchronous flush; empties pad, returns to IDLE
- i_In_rdy  input  1  upstream data valid
- o_In_ack  output  1  pad accepts data this cycle
- i_In_dat  input  DW  input activation
- i_rd_en  input  1  read request from controller (IPadAddr)
- i_rd_off  input  AW  offset from head (0 = oldest entry)
- o_rd_dat  output  DW  read data
- o_rd_vld  output  1  o_rd_dat valid
- i_pop  input  1  release entries from head
- i_pop_num  input  AW+1  number of entries released (1..DEPTH)
- o_count  output  AW+1  current occupancy
- o_full  output  1  count == DEPTH
- o_empty  output  1  count == 0
- o_err  output  1  sticky protocol error flag

Behaviour:
- Reset (async, i_rst_n low) forces:
  - state IDLE
  - head = tail = 0, count = 0
  - o_In_ack = 0, o_rd_vld = 0, o_rd_dat = 0, o_err = 0
  - o_empty = 1, o_full = 0
- Storage contents are don't-care after reset.
- States: IDLE and ACTIVE.
  - IDLE -> ACTIVE on i_start.
  - ACTIVE -> IDLE on i_clear.
  - i_clear has priority over i_start in the same cycle.
  - i_clear in IDLE is legal and empties the pad.
  - i_start in ACTIVE is ignored.
- Write handshake:
  - o_In_ack = (state == ACTIVE) && !o_full. Combinational, so a data beat can be accepted in the same cycle.
  - A beat transfers when i_In_rdy && o_In_ack: mem[tail] <= i_In_dat, tail <= tail + 1 mod DEPTH.
  - o_In_ack may assert without i_In_rdy.
  - Full: ack held low; nothing written.
  - Pop in the same cycle does not reopen ack until the next cycle.
- Read:
  - Latency is 1 cycle. If i_rd_en in cycle N, then in cycle N+1: o_rd_vld = 1, o_rd_dat = mem[(head + i_rd_off) mod DEPTH] using head as of cycle N.
  - Otherwise o_rd_vld = 0 and o_rd_dat holds its last value.
  - Offset >= count at cycle N: o_rd_vld still 1, data undefined, o_err set.
  - A read of the entry written in the same cycle N is not allowed (offset == count); it sets o_err.
  - Read while in IDLE sets o_err.
- Pop:
  - head <= head + i_pop_num mod DEPTH.
  - i_pop_num == 0 is a no-op.
  - i_pop_num > count saturates: head <= tail, count <= 0, o_err set.
- Occupancy:
  - count_nxt = count + (write ? 1 : 0) - (pop ? i_pop_num : 0), computed in AW+2 bits before saturation.
  - Write, pop and read in the same cycle are all legal. The read uses the pre-update head.
- Wrap-around: pointers wrap modulo DEPTH with no bubble; count distinguishes full from empty.
- o_count, o_full and o_empty are registered from count.
- i_clear:
  - next cycle: head = tail = count = 0, o_In_ack = 0, o_rd_vld = 0.
  - o_err is retained.
- o_err clears only on reset.

Decomposition:
- Shared package PECtlCfg, holding:
  - DW/DEPTH defaults
  - IPadAddr struct {rd_en, rd_off, pop, pop_num}, which the controller drives
  - pad state enum
- Sub-module pe_pad_ram: DEPTH x DW register file, one write port, one synchronous read port. It is reused later for the weight pad.
- Pointer, count and FSM logic stay in pe_input_pad.

Test Plan:
- Reset then i_start; stream 16 beats with i_In_rdy held high -> ack high for 16 cycles, o_full = 1 after the 16th beat, ack = 0 on the 17th cycle, o_count = 16.
- Fill values 0..15, then read offsets 0, 3, 15 back-to-back -> o_rd_dat = 0, 3, 15 on the following three cycles, each with o_rd_vld = 1.
- From full, pop 3 and read offset 0 in the same cycle -> read returns 0 (pre-pop head); next cycle o_count = 13, ack = 1; the next read of offset 0 returns 3.
- Wrap: write 20 values while popping 1 per cycle from count 8 -> tail wraps past 15, reads at offset 7 return the correct sequential values, no o_err.
- Pop 5 with count = 2 -> count = 0, o_empty = 1, o_err = 1 (sticky through i_clear, cleared only by i_rst_n).
- Assert i_rst_n low mid-stream with count = 9 -> o_In_ack, o_rd_vld and o_count drop to 0 asynchronously; after release, state is IDLE and ack stays 0 until i_start.
